// File: rtl/sr_latch_checker.sv
// Cycle-based checker for a gated SR latch: tracks the expected latch state and flags q/qbar mismatches.
// Define SR_CHK_COUNT_EN to build the saturating mismatch counter; otherwise err_cnt is tied to zero.
module sr_latch_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic [1:0]       state,
  output logic             exp_q,
  output logic             err,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_UNK = 2'b00,
    ST_RST = 2'b01,
    ST_SET = 2'b10,
    ST_INV = 2'b11
  } state_t;

  state_t cur, nxt;
  logic   mismatch;

  // The check uses the state held before this edge's command is applied.
  always_comb begin
    nxt      = cur;
    mismatch = 1'b0;
    if (en) begin
      unique case (cur)
        ST_RST:  mismatch = !((q == 1'b0) && (qbar == 1'b1));
        ST_SET:  mismatch = !((q == 1'b1) && (qbar == 1'b0));
        ST_INV:  mismatch = (q != qbar);
        default: mismatch = 1'b0;
      endcase
      unique case ({s, r})
        2'b01:   nxt = ST_RST;
        2'b10:   nxt = ST_SET;
        2'b11:   nxt = ST_INV;
        default: nxt = (cur == ST_INV) ? ST_UNK : cur;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= ST_UNK;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err        <= 1'b0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err     <= mismatch;
      illegal <= en & s & r;
      if (clr) begin
        err_sticky <= 1'b0;
      end else if (mismatch) begin
        err_sticky <= 1'b1;
      end
    end
  end

`ifdef SR_CHK_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (mismatch && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

  assign state = cur;
  assign exp_q = (cur == ST_SET);

endmodule
